// File: rtl/tt_clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package tt_clk_div_pkg;

    localparam int DEF_CNT_W = 4;
    localparam int MIN_DIV   = 2;

    // Flops on the scan path: c, act, pend (CNT_W each) plus pend_v, clk_p, ack, err, clk_n.
    function automatic int scan_len(input int cnt_w);
        return 3 * cnt_w + 5;
    endfunction

endpackage

// File: rtl/tt_prog_divide_by_n.sv
// Runtime-programmable 50%-duty clock divider with shadowed divisor updates,
// stop/start control, sticky illegal-divisor error and a full scan chain.
module tt_prog_divide_by_n
    import tt_clk_div_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int DEFAULT_DIV = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_div,
    input  logic             i_div_load,
    output logic [CNT_W-1:0] o_div_act,
    output logic             o_div_ack,
    output logic             o_err,
    output logic             o_clk,
    input  logic             i_scan_en,
    input  logic             i_scan_in,
    output logic             o_scan_out
);

    localparam int               SCAN_LEN = scan_len(CNT_W);
    localparam int               POS_LEN  = SCAN_LEN - 1;
    localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] c_q, c_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_v_q, pend_v_d;
    logic             clk_p_q, clk_p_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             clk_n_q, clk_n_d;

    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] c_step;
    logic             at_bnd;
    logic [POS_LEN-1:0] chain_q;

    // Posedge portion of the scan chain, c[0] nearest i_scan_in.
    assign chain_q = {err_q, ack_q, clk_p_q, pend_v_q, pend_q, act_q, c_q};

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        half     = act_q >> 1;
        at_bnd   = (c_q == act_q - ONE);
        c_step   = at_bnd ? '0 : c_q + ONE;

        c_d      = c_step;
        act_d    = act_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        clk_p_d  = (c_step < half);
        ack_d    = 1'b0;
        err_d    = err_q;

        if (at_bnd) begin
            if (!i_en) begin
                // Stopped: park on the last count so the next enable starts a fresh period.
                c_d     = c_q;
                clk_p_d = 1'b0;
                if (pend_v_q) begin
                    act_d    = pend_q;
                    c_d      = pend_q - ONE;
                    pend_v_d = 1'b0;
                    ack_d    = 1'b1;
                end
            end else begin
                c_d     = '0;
                clk_p_d = 1'b1;
                if (pend_v_q) begin
                    act_d    = pend_q;
                    pend_v_d = 1'b0;
                    ack_d    = 1'b1;
                end
            end
        end

        // A load coinciding with a boundary only becomes pending for the following one.
        if (i_div_load) begin
            if (i_div < CNT_W'(MIN_DIV)) begin
                err_d = 1'b1;
            end else begin
                pend_d   = i_div;
                pend_v_d = 1'b1;
            end
        end

        if (i_scan_en) begin
            {err_d, ack_d, clk_p_d, pend_v_d, pend_d, act_d, c_d} =
                {chain_q[POS_LEN-2:0], i_scan_in};
        end
    end

    assign clk_n_d = i_scan_en ? err_q : clk_p_q;

    // NOTE: sequential state uses non-blocking assignments; reset is asynchronous on every flop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            c_q      <= DIV_RST - ONE;
            act_q    <= DIV_RST;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            clk_p_q  <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            c_q      <= c_d;
            act_q    <= act_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            clk_p_q  <= clk_p_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
        end
    end

    // Half-cycle delayed copy; only stretches clk_p for odd divisors, never starts a pulse.
    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            clk_n_q <= 1'b0;
        end else begin
            clk_n_q <= clk_n_d;
        end
    end

    assign o_clk      = clk_p_q | (clk_n_q & act_q[0]);
    assign o_div_act  = act_q;
    assign o_div_ack  = ack_q;
    assign o_err      = err_q;
    assign o_scan_out = clk_n_q;

endmodule

// File: tb/tb_tt_prog_divide_by_n.sv
// Directed self-checking bench for tt_prog_divide_by_n (CNT_W=4, DEFAULT_DIV=3).
module tb_tt_prog_divide_by_n;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_en;
    logic [3:0] i_div;
    logic       i_div_load;
    logic [3:0] o_div_act;
    logic       o_div_ack;
    logic       o_err;
    logic       o_clk;
    logic       i_scan_en;
    logic       i_scan_in;
    logic       o_scan_out;

    int n_checks = 0;
    int n_pass   = 0;
    int ack_total = 0;

    tt_prog_divide_by_n #(.CNT_W(4), .DEFAULT_DIV(3)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_en       (i_en),
        .i_div      (i_div),
        .i_div_load (i_div_load),
        .o_div_act  (o_div_act),
        .o_div_ack  (o_div_ack),
        .o_err      (o_err),
        .o_clk      (o_clk),
        .i_scan_en  (i_scan_en),
        .i_scan_in  (i_scan_in),
        .o_scan_out (o_scan_out)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_div_ack === 1'b1) ack_total++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic half_step();
        @(posedge i_clk or negedge i_clk);
        #1;
    endtask

    // Waits for the next o_clk rise, then counts half-cycles high and low; ends on the following rise.
    task automatic measure(input string tag, input int exp_half);
        int   hi;
        int   lo;
        int   n;
        logic prev;
        bit   ok;
        ok   = 1'b0;
        prev = o_clk;
        for (int k = 0; k < 200; k++) begin
            half_step();
            if (o_clk && !prev) begin
                ok = 1'b1;
                break;
            end
            prev = o_clk;
        end
        check({tag, " rise"}, 32'(ok), 32'd1);
        if (!ok) return;
        hi = 1;
        n  = 0;
        half_step();
        while (o_clk && n < 200) begin
            hi++;
            n++;
            half_step();
        end
        lo = 1;
        half_step();
        while (!o_clk && n < 400) begin
            lo++;
            n++;
            half_step();
        end
        check({tag, " high halves"}, 32'(hi), 32'(exp_half));
        check({tag, " low halves"}, 32'(lo), 32'(exp_half));
    endtask

    task automatic load(input logic [3:0] div);
        i_div      = div;
        i_div_load = 1'b1;
        @(posedge i_clk);
        #1;
        i_div_load = 1'b0;
    endtask

    initial begin
        int          base;
        int          rises;
        logic        prev;
        logic [16:0] pat;
        logic [16:0] shout;

        i_rst_n    = 1'b0;
        i_en       = 1'b1;
        i_div      = '0;
        i_div_load = 1'b0;
        i_scan_en  = 1'b0;
        i_scan_in  = 1'b0;
        pat        = 17'b1_0110_0011_0101_0010;
        shout      = '0;

        // 1: reset state and default divide-by-3
        #12;
        check("rst o_clk", 32'(o_clk), 32'd0);
        check("rst act", 32'(o_div_act), 32'd3);
        check("rst ack", 32'(o_div_ack), 32'd0);
        check("rst err", 32'(o_err), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        check("first rise", 32'(o_clk), 32'd1);
        measure("div3", 3);

        // 2: load 4 at c=1, applied at the boundary
        base = ack_total;
        @(posedge i_clk);
        #1;
        load(4'd4);
        check("div4 pre act", 32'(o_div_act), 32'd3);
        check("div4 pre ack", 32'(o_div_ack), 32'd0);
        @(posedge i_clk);
        #1;
        check("div4 act", 32'(o_div_act), 32'd4);
        check("div4 ack", 32'(o_div_ack), 32'd1);
        check("div4 o_clk", 32'(o_clk), 32'd1);
        @(posedge i_clk);
        #1;
        check("div4 ack drop", 32'(o_div_ack), 32'd0);
        measure("div4", 4);
        check("div4 ack count", 32'(ack_total - base), 32'd1);

        // 3: two loads before one boundary, latest wins
        base = ack_total;
        load(4'd6);
        load(4'd5);
        measure("div5", 5);
        check("div5 act", 32'(o_div_act), 32'd5);
        check("div5 ack count", 32'(ack_total - base), 32'd1);

        // 4: illegal divisor sets the sticky error only
        base = ack_total;
        load(4'd1);
        check("err set", 32'(o_err), 32'd1);
        measure("div5 after err", 5);
        check("err act", 32'(o_div_act), 32'd5);
        check("err ack count", 32'(ack_total - base), 32'd0);

        // 5: stop at c=0 of N=4, load while stopped, restart
        load(4'd4);
        measure("div4 again", 4);
        check("err sticky", 32'(o_err), 32'd1);
        i_en  = 1'b0;
        rises = 0;
        prev  = o_clk;
        for (int k = 0; k < 24; k++) begin
            half_step();
            if (o_clk && !prev) rises++;
            prev = o_clk;
        end
        check("stop rises", 32'(rises), 32'd0);
        check("stop o_clk", 32'(o_clk), 32'd0);
        base = ack_total;
        load(4'd7);
        @(posedge i_clk);
        #1;
        check("stop ack", 32'(o_div_ack), 32'd1);
        check("stop act", 32'(o_div_act), 32'd7);
        check("stop o_clk low", 32'(o_clk), 32'd0);
        @(posedge i_clk);
        #1;
        check("stop o_clk held", 32'(o_clk), 32'd0);
        check("stop ack count", 32'(ack_total - base), 32'd1);
        i_en = 1'b1;
        measure("div7", 7);

        // boundary divisors: minimum and maximum
        base = ack_total;
        load(4'd2);
        measure("div2", 2);
        load(4'd15);
        measure("div15", 15);
        check("div15 act", 32'(o_div_act), 32'd15);
        check("edge ack count", 32'(ack_total - base), 32'd2);

        // 6: scan shift-through, then reset mid-shift
        i_en      = 1'b0;
        i_scan_en = 1'b1;
        for (int cyc = 0; cyc < 32; cyc++) begin
            i_scan_in = (cyc < 17) ? pat[cyc] : 1'b0;
            @(posedge i_clk);
            @(negedge i_clk);
            #1;
            if (cyc >= 15) shout[cyc-15] = o_scan_out;
        end
        check("scan pattern", 32'(shout), 32'(pat));
        for (int cyc = 0; cyc < 8; cyc++) begin
            i_scan_in = pat[cyc];
            @(posedge i_clk);
            #1;
        end
        #2;
        i_rst_n = 1'b0;
        #1;
        check("scan rst o_clk", 32'(o_clk), 32'd0);
        check("scan rst act", 32'(o_div_act), 32'd3);
        check("scan rst ack", 32'(o_div_ack), 32'd0);
        check("scan rst err", 32'(o_err), 32'd0);
        check("scan rst out", 32'(o_scan_out), 32'd0);
        i_scan_en = 1'b0;
        i_en      = 1'b1;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        check("post scan rise", 32'(o_clk), 32'd1);
        measure("post scan div3", 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tt_prog_divide_by_n.md
Name: tt_prog_divide_by_n

Overview:
- Runtime-programmable integer clock divider producing a 50% duty output for both odd and even divisors N ≥ 2.
- Divisor changes are shadowed and applied only at a period boundary, so no runt pulses occur.
- Includes a stop/start enable, a sticky error for illegal divisors and a continuous scan chain.
- Replaces the fixed divide-by-3 feedback divider in the clock generation path.

Parameters:
CNT_W, 4, counter/divisor width; legal divisors 2..2^CNT_W-1
DEFAULT_DIV, 3, divisor active out of reset; must be 2..2^CNT_W-1

Ports:
i_clk  in  1  source clock
i_rst_n  in  1  reset, active low
i_en  in  1  run request; sampled at period boundary
i_div  in  CNT_W  requested divisor
i_div_load  in  1  one-cycle strobe; captures i_div
o_div_act  out  CNT_W  divisor currently in effect
o_div_ack  out  1  one-cycle pulse when a pending divisor takes effect
o_err  out  1  sticky: a load with i_div < 2 was attempted
o_clk  out  1  divided clock, 50% duty
i_scan_en  in  1  scan shift enable
i_scan_in  in  1  scan data in
o_scan_out  out  1  scan data out

Interface: one clock; reset is asynchronous and active-low. Ports are i_clk and i_rst_n.

Behaviour:
- Reset (async, all flops):
  - c = DEFAULT_DIV-1, act = DEFAULT_DIV, pend = 0, pend_v = 0.
  - clk_p = 0, clk_n = 0, ack = 0, err = 0.
  - Outputs: o_clk = 0, o_div_ack = 0, o_err = 0, o_div_act = DEFAULT_DIV.
  - Reset mid-period forces o_clk low immediately.
- Let N = act and H = N>>1.
- Posedge counter c:
  - Normal step: c <= (c==N-1) ? 0 : c+1.
  - Registered high phase: clk_p <= (c_next < H).
  - clk_p is therefore high for H source cycles per period.
- Negedge flop clk_n <= clk_p (half-cycle delayed copy).
- Output: o_clk = clk_p | (clk_n & act[0]).
  - Even N: high N/2 cycles, low N/2 cycles.
  - Odd N: high H+0.5 cycles, low H+0.5 cycles.
  - o_clk is glitch-free because clk_n only ever extends clk_p.
- Boundary = posedge with c==N-1. At a boundary:
  - If i_en=0, hold c=N-1 and clk_p=0. o_clk goes low and stays low (stopped).
  - If i_en=1 and pend_v=1: act <= pend, pend_v <= 0, ack <= 1, c <= 0, clk_p <= 1.
  - If i_en=1 and pend_v=0: c <= 0, clk_p <= 1.
  - A deassert of i_en mid-period lets the current period complete.
- First o_clk rise is at the first posedge after reset release with i_en=1 (c wraps from DEFAULT_DIV-1).
- While stopped with pend_v=1: next posedge sets act <= pend, c <= pend-1, pend_v <= 0, ack <= 1. o_clk stays low.
- Load strobe (i_div_load=1):
  - If i_div < 2: ignored, err <= 1.
  - Otherwise: pend <= i_div, pend_v <= 1. The latest load overwrites any earlier pending value.
- Load in the same cycle as a boundary: the boundary uses the pre-edge pend/pend_v; the new value becomes pending for the next boundary.
- ack is high exactly one cycle per applied change; all other cycles it is 0.
- Scan (i_scan_en=1):
  - Shifting overrides all functional updates on both edges.
  - Chain order: i_scan_in → c[0..CNT_W-1] → act[0..] → pend[0..] → pend_v → clk_p → ack → err (posedge) → clk_n (negedge) → o_scan_out.
  - Length 3*CNT_W+5.
  - o_clk remains the combinational function of the flops during scan.
- Scan-loaded illegal state (c ≥ N, act < 2) is out of functional scope. c ≥ N must recover by wrapping through 2^CNT_W.

Decomposition:
- Package tt_clk_div_pkg: CNT_W default, MIN_DIV = 2, and function scan_len(CNT_W) = 3*CNT_W+5.
- No sub-module. The single negedge flop and the output OR stay inline; the block is small enough to remain one module.

Test Plan:
1. Reset, i_en=1, default N=3 → o_clk period 3 i_clk, high exactly 1.5 cycles; first rise on first posedge; o_div_act=3.
2. Load i_div=4 at c=1 of an N=3 period → no change until boundary; o_div_ack pulses once; then high 2 / low 2; o_div_act=4.
3. Load 6 then load 5 before the boundary → only 5 applied; a single ack; period 5, high 2.5.
4. Load i_div=1 → o_err=1 stays set; N unchanged; no ack; only reset clears o_err.
5. Drop i_en at c=0 of N=4 → period completes, o_clk held 0; load 7 while stopped → ack, o_div_act=7; raise i_en → period 7, high 3.5.
6. CNT_W=4: i_scan_en=1, shift 17-bit pattern 1_0110_0011_0101_0010 → appears on o_scan_out after 17 shifts (posedge/negedge ordering respected); assert reset mid-shift → all flops at reset values, o_clk=0.
